// File: rtl/prio_arbiter_rr_pkg.sv
// Shared definitions for the registered round-robin / fixed-priority arbiter:
// arbitration mode encodings and the grant FSM state type.
package prio_pkg;

  // Arbitration mode as seen on the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // IDLE: nothing offered. OFFER: a registered grant is waiting for gnt_ready.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

endpackage : prio_pkg

// File: rtl/prio_arbiter_rr_pick.sv
// Combinational circular-downward winner search.
// Starting at index `start`, the search visits start, start-1, ..., 0, then
// wraps to N-1, ..., start+1. The first requester found in that order wins.
module prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  // Walk the circular order once and latch onto the first set request bit.
  always_comb begin
    int pos;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(start) - i;
      if (pos < 0) begin
        pos = pos + N;
      end
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
    if (found) begin
      onehot = N'(1) << idx;
    end
  end

endmodule : prio_pick

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter with fixed-priority (highest index wins) and
// round-robin modes. The winner is offered on a valid/ready handshake as a
// binary index plus a one-hot vector and is held stable until accepted.
// All grant outputs come straight from flops; req_none is the only
// combinational output.
module prio_arbiter_rr
  import prio_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic             req_none
);

  // Highest requester index; the pointer's reset value and fixed-mode start.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             handshake;
  logic [IDX_W-1:0] ptr_post;
  logic [IDX_W-1:0] search_start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;

  assign req_none = ~|req;

  // Pointer as it will be after this cycle's transfer, and the search start:
  // round-robin starts just below the last accepted winner, fixed mode always
  // starts at the top so the highest set index wins.
  always_comb begin
    handshake = (state == ST_OFFER) && gnt_ready;
    ptr_post  = ptr;
    if (handshake) begin
      ptr_post = (gnt_idx == '0) ? LAST_IDX : (gnt_idx - IDX_W'(1));
    end
    search_start = (mode == MODE_RR) ? ptr_post : LAST_IDX;
  end

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .start  (search_start),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Grant FSM: loads a winner from IDLE, holds it sticky in OFFER, and on a
  // transfer either reloads back-to-back or drops to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: this block only holds a handful of control flops, so every one of
    // them is reset; there is no storage array here that would need to stay
    // unreset.
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      state      <= ST_IDLE;
      ptr        <= LAST_IDX;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state      <= ST_OFFER;
            gnt_valid  <= 1'b1;
            gnt_idx    <= pick_idx;
            gnt_onehot <= pick_onehot;
          end
        end
        ST_OFFER: begin
          if (gnt_ready) begin
            ptr <= ptr_post;
            if (pick_found) begin
              gnt_idx    <= pick_idx;
              gnt_onehot <= pick_onehot;
            end else begin
              state      <= ST_IDLE;
              gnt_valid  <= 1'b0;
              gnt_onehot <= '0;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          gnt_valid  <= 1'b0;
          gnt_onehot <= '0;
        end
      endcase
    end
  end

endmodule : prio_arbiter_rr

// File: doc/prio_arbiter_rr.md
# prio_arbiter_rr

Parametrised, registered successor to the combinational 8-bit priority encoder. It arbitrates among `N` request lines in one of two modes: fixed priority (highest index wins) or round-robin. The winner is presented on a valid/ready handshake as a binary index plus a one-hot vector, and it stays stable until accepted. It sits between request sources and a shared resource in the Tiny Tapeout user design.

## Interface
Parameters:
- `N`, default 8, number of requesters; legal range 2..64.
- `IDX_W`, default `$clog2(N)`, width of the index; derived, never overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  N  request vector; bit k = requester k wants a grant.
- `mode`  in  1  0 = fixed priority, 1 = round-robin; sampled only at winner evaluation.
- `gnt_valid`  out  1  a grant is being offered.
- `gnt_ready`  in  1  consumer accepts the offered grant.
- `gnt_idx`  out  IDX_W  binary index of the winner.
- `gnt_onehot`  out  N  one-hot form of `gnt_idx`; all zero when `gnt_valid` = 0.
- `req_none`  out  1  combinational `~|req`.

## Operation
- States: IDLE (`gnt_valid` = 0) and OFFER (`gnt_valid` = 1).
- Priority pointer `ptr` (IDX_W bits):
  - Reset value is `N-1`.
  - Search order is `ptr`, `ptr-1`, …, 0, then wraps to `N-1`, …, `ptr+1`.
  - The first set bit of `req` in that order wins.
- Fixed mode searches from `N-1` regardless of `ptr`, so the highest set index wins. This matches the priority-encoder rule.
- `ptr` update:
  - On every accepted grant of index k, in either mode, `ptr` becomes k-1, with 0 wrapping to `N-1`.
  - `ptr` does not change otherwise.
- IDLE:
  - If `req` ≠ 0, evaluate the winner, register `gnt_idx`/`gnt_onehot`, and go to OFFER.
  - Otherwise stay in IDLE; outputs stay zero.
- OFFER with `gnt_ready` = 0:
  - Hold all grant outputs stable.
  - The grant is sticky: it is not retracted or changed even if the winner's `req` bit drops or higher requests appear.
- OFFER with `gnt_ready` = 1 (handshake):
  - If `req` ≠ 0 in this cycle, evaluate a new winner using the post-handshake `ptr` and current `mode`, load it, and stay in OFFER (back-to-back).
  - Otherwise go to IDLE and clear `gnt_onehot`.
- `gnt_ready` in IDLE is ignored.
- `mode` change while in OFFER does not affect the held grant; it applies at the next evaluation.
- `rst` asserted in any state, including mid-handshake:
  - Next edge gives `gnt_valid` = 0, `gnt_idx` = 0, `gnt_onehot` = 0, `ptr` = `N-1`, state IDLE.
  - The handshake in that cycle is discarded.

## Timing
- Latency from `req` to `gnt_valid`: 1 cycle. A request seen at edge t produces a grant visible after edge t.
- Throughput: one grant per cycle while `gnt_ready` = 1 and `req` ≠ 0.
- A transfer occurs on a rising edge where `gnt_valid` & `gnt_ready` = 1.
- `gnt_idx`, `gnt_onehot` and `gnt_valid` are driven directly from flops, with no combinational path from `req` or `gnt_ready`.
- `req_none` is the only combinational output.
- Reset values: `gnt_valid` 0, `gnt_idx` 0, `gnt_onehot` 0; internal `ptr` `N-1`.

## Structure
- Shared package `prio_pkg` contains:
  - `MODE_FIXED` = 1'b0 and `MODE_RR` = 1'b1 constants.
  - State enum {`ST_IDLE`, `ST_OFFER`}.
- One combinational sub-module, `prio_pick`:
  - Inputs: `N`-bit `req` and a start index.
  - Outputs: `found`, winner index and one-hot.
  - Implementation: circular downward search, done as a doubled-vector mask or a loop.
- The top level holds the FSM, `ptr`, and the output registers.

## Test plan
- Fixed priority: N=8, reset, `mode`=0, `req`=8'h24, `gnt_ready`=1 → one cycle later `gnt_valid`=1, `gnt_idx`=5, `gnt_onehot`=8'h20.
- Sticky hold: from the previous offer, `gnt_ready`=0 for 3 cycles while `req` changes to 8'h80 → `gnt_idx` stays 5. On `gnt_ready`=1 the next grant is 7.
- Round-robin full load: `mode`=1, `req`=8'hFF, `gnt_ready`=1 constantly → `gnt_idx` sequence 7,6,5,4,3,2,1,0,7, one per cycle.
- Round-robin two requesters: `mode`=1, `req`=8'h81 → grants alternate 7,0,7,0. Switching to `mode`=0 → grants become 7,7,7.
- Empty and reset: `req`=0 → `gnt_valid` stays 0 and `req_none`=1. Assert `rst` during OFFER with `gnt_ready`=1 → next cycle all outputs are 0, and a subsequent RR grant on 8'hFF is 7.
- Width change: N=5, `mode`=1, `req`=5'h1F → sequence 4,3,2,1,0,4. `gnt_idx` width is 3.
